// File: rtl/riscv_dmem_ctrl.sv
// Data-memory access controller: queues core accesses, screens alignment,
// issues aligned ones in order on a pipelined req/gnt bus, acks in order.
module riscv_dmem_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dmem_req,
    input  logic [XLEN-1:0]   dmem_adr,
    input  logic [XLEN-1:0]   dmem_d,
    input  logic              dmem_we,
    input  logic [XLEN/8-1:0] dmem_be,
    output logic              dmem_rdy,
    output logic              dmem_ack,
    output logic [XLEN-1:0]   dmem_q,
    output logic              dmem_misaligned,
    output logic              dmem_err,
    output logic              bus_req,
    output logic [XLEN-1:0]   bus_adr,
    output logic [XLEN-1:0]   bus_d,
    output logic              bus_we,
    output logic [XLEN/8-1:0] bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_q,
    input  logic              bus_err
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // queue payload and per-entry status
    logic [XLEN-1:0] q_adr   [DEPTH];
    logic [XLEN-1:0] q_d     [DEPTH];
    logic            q_we    [DEPTH];
    logic [NB-1:0]   q_be    [DEPTH];
    logic [XLEN-1:0] q_rdata [DEPTH];
    logic            q_rerr  [DEPTH];
    logic [DEPTH-1:0] q_mis;
    logic [DEPTH-1:0] q_iss;
    logic [DEPTH-1:0] q_done;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] rsp_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] n_pend;

    logic          acc;
    logic          in_mis;
    logic          gnt_fire;
    logic          skip;
    logic          adv;
    logic [PW-1:0] iss_nxt;
    logic          old_avail;
    logic          nxt_req;
    logic [XLEN-1:0] nxt_adr;
    logic [XLEN-1:0] nxt_d;
    logic          nxt_we;
    logic [NB-1:0] nxt_be;

    logic          tgt_hit;
    logic [PW-1:0] tgt;
    logic [PW-1:0] idx;
    logic          rv_take;
    logic          ret;

    // legal: aligned power-of-two run of lanes whose start matches the address
    function automatic logic calc_mis(input logic [LB-1:0] off,
                                      input logic [NB-1:0] be);
        logic          ok;
        logic [NB-1:0] mask;
        int            run;
        ok = 1'b0;
        for (int k = 0; k <= LB; k++) begin
            run = 1 << k;
            for (int o = 0; o < NB; o++) begin
                mask = NB'(((1 << run) - 1) << o);
                if ((o % run) == 0 && (o + run) <= NB &&
                    be == mask && off == LB'(o))
                    ok = 1'b1;
            end
        end
        return !ok;
    endfunction

    assign dmem_rdy = (count != CW'(DEPTH));
    assign acc      = dmem_req & dmem_rdy;
    assign in_mis   = calc_mis(dmem_adr[LB-1:0], dmem_be);

    // pick the entry to present on the bus after this edge (bypasses new accept)
    always_comb begin
        gnt_fire  = bus_req & bus_gnt;
        skip      = !bus_req && (n_pend != '0) && q_mis[iss_ptr];
        adv       = gnt_fire | skip;
        iss_nxt   = iss_ptr + PW'(adv);
        old_avail = (n_pend - CW'(adv)) != '0;
        nxt_req   = 1'b0;
        nxt_adr   = bus_adr;
        nxt_d     = bus_d;
        nxt_we    = bus_we;
        nxt_be    = bus_be;
        if (old_avail) begin
            nxt_req = !q_mis[iss_nxt];
            nxt_adr = q_adr[iss_nxt];
            nxt_d   = q_d[iss_nxt];
            nxt_we  = q_we[iss_nxt];
            nxt_be  = q_be[iss_nxt];
        end else if (acc) begin
            nxt_req = !in_mis;
            nxt_adr = dmem_adr;
            nxt_d   = dmem_d;
            nxt_we  = dmem_we;
            nxt_be  = dmem_be;
        end
    end

    // route bus response to oldest granted entry, decide in-order retire
    always_comb begin
        tgt_hit = 1'b0;
        tgt     = rsp_ptr;
        idx     = rsp_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rsp_ptr + PW'(k);
            if (!tgt_hit && q_iss[idx] && !q_mis[idx] && !q_done[idx]) begin
                tgt_hit = 1'b1;
                tgt     = idx;
            end
        end
        rv_take = bus_rvalid & tgt_hit;
        ret = (count != '0) && q_iss[rsp_ptr] &&
              (q_mis[rsp_ptr] || q_done[rsp_ptr] ||
               (rv_take && tgt == rsp_ptr));
    end

    // queue, pointers, registered bus request and core ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr          <= '0;
            iss_ptr         <= '0;
            rsp_ptr         <= '0;
            count           <= '0;
            n_pend          <= '0;
            q_mis           <= '0;
            q_iss           <= '0;
            q_done          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_adr[i]   <= '0;
                q_d[i]     <= '0;
                q_we[i]    <= 1'b0;
                q_be[i]    <= '0;
                q_rdata[i] <= '0;
                q_rerr[i]  <= 1'b0;
            end
            bus_req         <= 1'b0;
            bus_adr         <= '0;
            bus_d           <= '0;
            bus_we          <= 1'b0;
            bus_be          <= '0;
            dmem_ack        <= 1'b0;
            dmem_q          <= '0;
            dmem_misaligned <= 1'b0;
            dmem_err        <= 1'b0;
        end else begin
            if (acc) begin
                q_adr[wr_ptr]  <= dmem_adr;
                q_d[wr_ptr]    <= dmem_d;
                q_we[wr_ptr]   <= dmem_we;
                q_be[wr_ptr]   <= dmem_be;
                q_mis[wr_ptr]  <= in_mis;
                q_iss[wr_ptr]  <= 1'b0;
                q_done[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (adv) begin
                q_iss[iss_ptr] <= 1'b1;
                iss_ptr        <= iss_nxt;
            end
            if (rv_take) begin
                q_done[tgt]  <= 1'b1;
                q_rdata[tgt] <= bus_q;
                q_rerr[tgt]  <= bus_err;
            end
            if (ret) begin
                q_iss[rsp_ptr] <= 1'b0;
                rsp_ptr        <= rsp_ptr + 1'b1;
            end
            count  <= count + CW'(acc) - CW'(ret);
            n_pend <= n_pend + CW'(acc) - CW'(adv);

            bus_req <= nxt_req;
            if (nxt_req) begin
                bus_adr <= nxt_adr;
                bus_d   <= nxt_d;
                bus_we  <= nxt_we;
                bus_be  <= nxt_be;
            end

            dmem_ack <= ret;
            if (ret) begin
                unique case (1'b1)
                    q_mis[rsp_ptr]: begin
                        dmem_q          <= '0;
                        dmem_misaligned <= 1'b1;
                        dmem_err        <= 1'b0;
                    end
                    q_done[rsp_ptr]: begin
                        dmem_q          <= q_we[rsp_ptr] ? '0 : q_rdata[rsp_ptr];
                        dmem_misaligned <= 1'b0;
                        dmem_err        <= q_rerr[rsp_ptr];
                    end
                    default: begin
                        dmem_q          <= q_we[rsp_ptr] ? '0 : bus_q;
                        dmem_misaligned <= 1'b0;
                        dmem_err        <= bus_err;
                    end
                endcase
            end
        end
    end

endmodule
